dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the core load/store path (MEM stage) and a debug/DMA port.
- Per access it sequences the memory control strobes, waits for memory ready with a bounded timeout, and returns read data plus completion.
- Generates the core pipeline stall while a core access is outstanding.
- Sits between the MEM stage and the DM macro; read data it returns feeds the writeback load-alignment path.

Parameters:
ADDR_W, 14, word-address width driven on DM_A
STARVE_LIMIT, 4, consecutive core grants with debug waiting before debug is forced to win (1..15)
MAX_WAIT, 15, ACCESS cycles with DM_RDY low before timeout abort (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  core access request; held with payload until core_rvalid
core_we  in  1  1=store, 0=load
core_be  in  4  byte enables
core_addr  in  32  byte address
core_wdata  in  32  store data, pre-aligned to byte lanes
core_gnt  out  1  1-cycle pulse: core access issued
core_rvalid  out  1  1-cycle pulse: core access complete
core_rdata  out  32  raw memory word, valid with core_rvalid
core_err  out  1  timeout flag, valid with core_rvalid
core_stall  out  1  core_req & ~core_rvalid
dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata  in  1/1/4/32/32  debug request, same contract as core
dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err  out  1/1/32/1  debug response, same contract as core
DM_CS  out  1  memory chip select
DM_OE  out  1  memory output enable (loads)
DM_WEB  out  4  active-low byte write enables
DM_A  out  ADDR_W  word address = addr[ADDR_W+1:2]
DM_DO  out  32  write data to memory
DM_DI  in  32  read data from memory
DM_RDY  in  1  access complete this cycle

Behaviour:
- Reset (rst=0, asynchronous, any state): FSM=IDLE; starve_cnt=0; wait_cnt=0; DM_CS=0, DM_OE=0, DM_WEB=4'hF, DM_A=0, DM_DO=0; all gnt/rvalid/err=0; rdata=0. An in-flight access is dropped with no response; requesters re-issue.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Only one outstanding access.
- IDLE, no req: stay. Any req: arbitrate, latch the winner's payload into registers, record owner, go to ACCESS.
- Arbitration:
  - Core wins by default.
  - Debug wins if only dbg_req, or if both req and starve_cnt==STARVE_LIMIT.
  - starve_cnt increments on each core grant with dbg_req high, saturating at STARVE_LIMIT.
  - starve_cnt clears on a debug grant, or in IDLE when dbg_req=0.
- ACCESS:
  - Outputs are registered from latched payload: DM_CS=1, DM_A, DM_DO=wdata, DM_OE=~we, DM_WEB = we ? ~be : 4'hF.
  - Owner gnt=1 only in the first ACCESS cycle.
  - DM_RDY=1: capture DM_DI into owner rdata for loads; stores write rdata=0. err=0. Go to RESP.
  - DM_RDY=0: wait_cnt++. If wait_cnt reaches MAX_WAIT: rdata=0, err=1, go to RESP.
  - wait_cnt clears on ACCESS entry.
- RESP: DM_CS=0, DM_OE=0, DM_WEB=4'hF. Owner rvalid=1 for exactly one cycle, then IDLE.
- Requester contract: a req still high in the IDLE cycle after rvalid is a new access.
- rdata/err hold their value until that port's next completion.
- Latency with zero-wait memory: req seen in IDLE cycle t -> gnt at t+1 -> rvalid at t+2. Each DM_RDY=0 cycle adds one cycle.
- core_stall is combinational from core_req and registered core_rvalid. It is high from the core_req rising edge through the ACCESS cycles and low in the RESP cycle.
- Payload changes while req is held are ignored after latch.
- DM_RDY outside ACCESS is ignored.

Decomposition:
- dmem_pkg: state_e {IDLE, ACCESS, RESP}; owner_e {OWN_CORE, OWN_DBG}; req_t struct {we, be[3:0], addr[31:0], wdata[31:0]}.
- Sub-module dmem_arb_pick: inputs core_req, dbg_req, grant strobe; contains starve_cnt; outputs winner owner_e. Main module holds the FSM, payload registers, wait_cnt and response registers.

Test Plan:
- Core load addr=0x0000_0010, DM_DI=0xDEADBEEF, DM_RDY=1 -> gnt at t+1 with DM_A=4, DM_OE=1, DM_WEB=F; core_rvalid at t+2, core_rdata=0xDEADBEEF; core_stall high at t and t+1, low at t+2.
- Core store be=4'b0011, wdata=0x0000_1234, DM_RDY low 3 cycles -> DM_WEB=4'b1100 and DM_DO=0x1234 for 4 ACCESS cycles; rvalid 1 cycle after DM_RDY, core_rdata=0, core_err=0.
- core_req and dbg_req both held continuously, STARVE_LIMIT=4 -> grant order core,core,core,core,dbg,core… ; dbg_gnt on the 5th grant.
- DM_RDY stuck 0, MAX_WAIT=15 -> 15 ACCESS cycles, then dbg_rvalid=1, dbg_err=1, dbg_rdata=0; the next access completes normally with err=0.
- rst pulled low during ACCESS of a debug store -> DM_CS=0, DM_WEB=F asynchronously; no dbg_rvalid; after release a core req is granted from IDLE.
- Back-to-back core loads with req held across rvalid -> second gnt exactly 2 cycles after first rvalid (RESP->IDLE->ACCESS); no gaps or duplicates.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access owner and the
// latched request payload.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_DBG
    } owner_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam int unsigned WAIT_W    = 8;
    localparam int unsigned STARVE_W  = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Core-vs-debug winner selection with a starvation counter that forces the
// debug port through after STARVE_LIMIT consecutive core grants.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   idle,
    input  logic   grant,
    input  logic   core_req,
    input  logic   dbg_req,
    output owner_e winner
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starved;

    assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        winner = OWN_CORE;
        if (dbg_req && (!core_req || starved)) begin
            winner = OWN_DBG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (idle && !dbg_req) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_DBG) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for the single-ported data memory: arbitrates,
// drives registered DM strobes, bounds the ready wait and returns responses.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [3:0]        core_be,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    output logic              core_err,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_be,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,
    output logic              DM_CS,
    output logic              DM_OE,
    output logic [3:0]        DM_WEB,
    output logic [ADDR_W-1:0] DM_A,
    output logic [31:0]       DM_DO,
    input  logic [31:0]       DM_DI,
    input  logic              DM_RDY
);

    state_e              state;
    owner_e              owner;
    owner_e              winner;
    logic                pay_we;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                timeout;
    logic                idle;
    logic                grant;
    req_t                core_pl;
    req_t                dbg_pl;
    req_t                sel;
    logic [31:0]         rd_word;
    logic                unused_addr;

    assign idle    = (state == IDLE);
    assign grant   = idle && (core_req || dbg_req);
    assign core_pl = '{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata};
    assign dbg_pl  = '{we: dbg_we, be: dbg_be, addr: dbg_addr, wdata: dbg_wdata};
    assign sel     = (winner == OWN_DBG) ? dbg_pl : core_pl;

    assign unused_addr = ^{sel.addr[31:ADDR_W+2], sel.addr[1:0]};

    assign wait_nxt = wait_cnt + WAIT_W'(1);
    assign timeout  = (wait_nxt == WAIT_W'(MAX_WAIT));
    // Stores and timeouts both return a zero word.
    assign rd_word  = (DM_RDY && !pay_we) ? DM_DI : '0;

    assign core_stall = core_req & ~core_rvalid;

    dmem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .idle     (idle),
        .grant    (grant),
        .core_req (core_req),
        .dbg_req  (dbg_req),
        .winner   (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWN_CORE;
            pay_we      <= 1'b0;
            wait_cnt    <= '0;
            DM_CS       <= 1'b0;
            DM_OE       <= 1'b0;
            DM_WEB      <= '1;
            DM_A        <= '0;
            DM_DO       <= '0;
            core_gnt    <= 1'b0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            core_err    <= 1'b0;
            dbg_gnt     <= 1'b0;
            dbg_rvalid  <= 1'b0;
            dbg_rdata   <= '0;
            dbg_err     <= 1'b0;
        end else begin
            core_gnt    <= 1'b0;
            dbg_gnt     <= 1'b0;
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner    <= winner;
                        pay_we   <= sel.we;
                        wait_cnt <= '0;
                        DM_CS    <= 1'b1;
                        DM_OE    <= ~sel.we;
                        DM_WEB   <= sel.we ? ~sel.be : 4'hF;
                        DM_A     <= sel.addr[ADDR_W+1:2];
                        DM_DO    <= sel.wdata;
                        if (winner == OWN_DBG) begin
                            dbg_gnt <= 1'b1;
                        end else begin
                            core_gnt <= 1'b1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (DM_RDY || timeout) begin
                        DM_CS  <= 1'b0;
                        DM_OE  <= 1'b0;
                        DM_WEB <= '1;
                        if (owner == OWN_DBG) begin
                            dbg_rdata  <= rd_word;
                            dbg_err    <= ~DM_RDY;
                            dbg_rvalid <= 1'b1;
                        end else begin
                            core_rdata  <= rd_word;
                            core_err    <= ~DM_RDY;
                            core_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants and
// responses, a monitor checks DM strobes and completions against them.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W       = 14;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned MAX_WAIT     = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              core_req, core_we, core_gnt, core_rvalid, core_err, core_stall;
    logic [3:0]        core_be;
    logic [31:0]       core_addr, core_wdata, core_rdata;
    logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
    logic [3:0]        dbg_be;
    logic [31:0]       dbg_addr, dbg_wdata, dbg_rdata;
    logic              DM_CS, DM_OE, DM_RDY;
    logic [3:0]        DM_WEB;
    logic [ADDR_W-1:0] DM_A;
    logic [31:0]       DM_DO, DM_DI;

    dmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_be(core_be),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_err(core_err), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_err(dbg_err),
        .DM_CS(DM_CS), .DM_OE(DM_OE), .DM_WEB(DM_WEB), .DM_A(DM_A),
        .DM_DO(DM_DO), .DM_DI(DM_DI), .DM_RDY(DM_RDY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                dbg;
        logic [ADDR_W-1:0] a;
        logic [3:0]        web;
        logic              oe;
        logic [31:0]       dout;
        int                gap;
    } gexp_t;

    typedef struct {
        bit          dbg;
        logic [31:0] rdata;
        logic        err;
        int          ncyc;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Memory model: DM_RDY rises on the lat-th ACCESS cycle (0-based).
    int          lat      = 0;
    logic [31:0] mem_word = '0;
    int          k        = 0;
    initial begin
        DM_RDY = 1'b0;
        DM_DI  = '0;
        forever begin
            @(negedge clk);
            if (DM_CS === 1'b1) begin
                DM_RDY = (k == lat);
                k++;
            end else begin
                DM_RDY = 1'b0;
                k      = 0;
            end
            DM_DI = mem_word;
        end
    end

    // Monitor: grants, per-cycle DM strobes, completions.
    gexp_t cur;
    bit    cur_ok  = 1'b0;
    int    cs_cnt  = 0;
    int    last_rv = -100;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                cs_cnt = 0;
                cur_ok = 1'b0;
            end else begin
                if (core_gnt || dbg_gnt) begin
                    if (gq.size() == 0) begin
                        bad("unexpected_gnt");
                    end else begin
                        cur    = gq.pop_front();
                        cur_ok = 1'b1;
                        chk("gnt_owner", {core_gnt, dbg_gnt}, cur.dbg ? 2'b01 : 2'b10);
                        if (cur.gap >= 0) chk("gnt_gap", cyc - last_rv, cur.gap);
                    end
                end
                if (DM_CS) begin
                    cs_cnt++;
                    if (cur_ok) begin
                        chk("dm_a", DM_A, cur.a);
                        chk("dm_web", DM_WEB, cur.web);
                        chk("dm_oe", DM_OE, cur.oe);
                        chk("dm_do", DM_DO, cur.dout);
                    end else begin
                        bad("dm_cs_without_gnt");
                    end
                end
                if (core_rvalid || dbg_rvalid) begin
                    last_rv = cyc;
                    if (rq.size() == 0) begin
                        bad("unexpected_rvalid");
                    end else begin
                        rexp_t r;
                        r = rq.pop_front();
                        chk("rv_owner", {core_rvalid, dbg_rvalid}, r.dbg ? 2'b01 : 2'b10);
                        chk("rdata", r.dbg ? dbg_rdata : core_rdata, r.rdata);
                        chk("err", r.dbg ? dbg_err : core_err, r.err);
                        chk("access_cycles", cs_cnt, r.ncyc);
                        chk("resp_cs", DM_CS, 1'b0);
                        chk("resp_web", DM_WEB, 4'hF);
                    end
                    cs_cnt = 0;
                    cur_ok = 1'b0;
                end
            end
        end
    end

    task automatic set_port(input bit dbg, input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (dbg) begin
            dbg_req = req; dbg_we = we; dbg_be = be; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            core_req = req; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
        end
    endtask

    // One access; payload is scrambled after the grant to show it was latched.
    task automatic access(input bit dbg, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input int l,
                          input logic [31:0] word, input int exp_cyc, input logic exp_err);
        gexp_t g;
        rexp_t r;
        bit    done = 1'b0;
        lat      = l;
        mem_word = word;
        g = '{dbg, addr[ADDR_W+1:2], we ? ~be : 4'hF, ~we, wdata, -1};
        r = '{dbg, (!we && !exp_err) ? word : 32'h0, exp_err, exp_cyc};
        gq.push_back(g);
        rq.push_back(r);
        @(negedge clk);
        set_port(dbg, 1'b1, we, be, addr, wdata);
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (dbg ? dbg_gnt : core_gnt)
                set_port(dbg, 1'b1, ~we, ~be, addr ^ 32'h0000_3FFC, ~wdata);
            if (dbg ? dbg_rvalid : core_rvalid) begin
                done = 1'b1;
                set_port(dbg, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end
        if (!done) begin
            bad("rvalid_timeout");
            set_port(dbg, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        set_port(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_cs", DM_CS, 1'b0);
        chk("rst_oe", DM_OE, 1'b0);
        chk("rst_web", DM_WEB, 4'hF);
        chk("rst_a", DM_A, '0);
        chk("rst_do", DM_DO, 32'h0);
        chk("rst_pulses", {core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err}, 6'b0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_stall", core_stall, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait core load with latency and stall checks
        lat      = 0;
        mem_word = 32'hDEAD_BEEF;
        gq.push_back('{1'b0, 14'd4, 4'hF, 1'b1, 32'h0, -1});
        rq.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0, 1});
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        #1 chk("stall_t", core_stall, 1'b1);
        @(negedge clk);
        chk("gnt_t1", core_gnt, 1'b1);
        chk("stall_t1", core_stall, 1'b1);
        @(negedge clk);
        chk("rvalid_t2", core_rvalid, 1'b1);
        chk("stall_t2", core_stall, 1'b0);
        core_req = 1'b0;
        @(negedge clk);
        chk("rvalid_pulse", core_rvalid, 1'b0);
        chk("rdata_hold", core_rdata, 32'hDEAD_BEEF);

        // Core store, 3 wait states -> 4 ACCESS cycles, zero rdata
        access(1'b0, 1'b1, 4'b0011, 32'h0000_0020, 32'h0000_1234, 3, 32'hDEAD_BEEF, 4, 1'b0);

        // Starvation: both held, order core x4, dbg, core
        lat      = 0;
        mem_word = 32'hA5A5_0001;
        for (int i = 0; i < 6; i++) begin
            gq.push_back('{i == 4, (i == 4) ? 14'h20 : 14'h10, 4'hF, 1'b1, 32'h0, -1});
            rq.push_back('{i == 4, 32'hA5A5_0001, 1'b0, 1});
        end
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
        begin
            int n = 0;
            for (int i = 0; i < 200 && n < 6; i++) begin
                @(negedge clk);
                if (core_rvalid || dbg_rvalid) n++;
                if (n == 6) begin
                    set_port(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                    set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                end
            end
            if (n < 6) begin
                bad("starve_timeout");
                set_port(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end

        // Timeout on a debug load, then a normal debug load
        access(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 255, 32'h7777_7777, 15, 1'b1);
        access(1'b1, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 1, 32'h1357_9BDF, 2, 1'b0);

        // Async reset in the middle of a debug store
        lat      = 255;
        gq.push_back('{1'b1, 14'h80, 4'h0, 1'b0, 32'hCAFE_F00D, -1});
        @(negedge clk);
        set_port(1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_cs", DM_CS, 1'b0);
        chk("arst_web", DM_WEB, 4'hF);
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_no_rvalid", dbg_rvalid, 1'b0);
        end
        rst = 1'b1;
        access(1'b0, 1'b0, 4'hF, 32'h0000_0008, 32'h0, 0, 32'h0BAD_F00D, 1, 1'b0);

        // Back-to-back core loads with req held across rvalid
        lat      = 0;
        mem_word = 32'h1111_2222;
        gq.push_back('{1'b0, 14'hC, 4'hF, 1'b1, 32'h0, -1});
        gq.push_back('{1'b0, 14'hD, 4'hF, 1'b1, 32'h0, 2});
        rq.push_back('{1'b0, 32'h1111_2222, 1'b0, 1});
        rq.push_back('{1'b0, 32'h3333_4444, 1'b0, 1});
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0030, 32'h0);
        begin
            int n = 0;
            for (int i = 0; i < 50 && n < 2; i++) begin
                @(negedge clk);
                if (core_rvalid) begin
                    n++;
                    if (n == 1) begin
                        core_addr = 32'h0000_0034;
                        mem_word  = 32'h3333_4444;
                    end else begin
                        core_req = 1'b0;
                    end
                end
            end
            if (n < 2) begin
                bad("b2b_timeout");
                core_req = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        chk("gq_drained", gq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
